// File: rtl/lsu.sv
// Load-store unit: turns sized core loads/stores into word-wide memory accesses
// with byte enables, and stalls the core until the memory responds.
module lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size and offset are captured at request acceptance; the load result is
    // extracted from them later, when the memory data arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && core_req_i) begin
                size_q <= core_size_i;
                off_q  <= core_addr_i[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (core_req_i)  state_d = WAIT;
            WAIT:    if (mem_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The request stays asserted in WAIT, so memory simply repeats the same access.
    always_comb begin
        mem_req_o    = core_req_i & ~rst_i;
        core_stall_o = core_req_i & ~rst_i & ~((state_q == WAIT) & mem_ready_i);
        mem_we_o     = core_we_i;
        mem_addr_o   = core_addr_i;

        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
        if (!core_we_i) mem_be_o = 4'b0000;
    end

    // Size encodings 3, 6 and 7 fall through to a plain word access.
    always_comb begin
        ld_byte   = mem_rd_i[{off_q, 3'b000} +: 8];
        ld_half   = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        core_rd_o = mem_rd_i;
        case (size_q[1:0])
            2'd0:    core_rd_o = {{24{ld_byte[7] & ~size_q[2]}}, ld_byte};
            2'd1:    core_rd_o = {{16{ld_half[15] & ~size_q[2]}}, ld_half};
            default: core_rd_o = mem_rd_i;
        endcase
        if (rst_i) core_rd_o = 32'd0;
    end

endmodule
